// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction-fetch / load-store arbiter in front
// of the byte-wide RAM: bus widths, mem_len encodings, FSM state encodings,
// stall-request enables and the small byte-lane helpers used for assembly.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    // Byte counter must reach 4 (the capture-only cycle of a word read).
    localparam int unsigned CNT_W  = 3;

    // Stall-request enables towards the stage-register stall controller.
    localparam logic STALL_IF_EN  = 1'b1;
    localparam logic STALL_MEM_EN = 1'b1;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2,
        LEN_RSVD = 2'd3
    } mem_len_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

    // Number of bytes moved for a given mem_len; the reserved code is a word.
    function automatic logic [CNT_W-1:0] len_to_bytes(input logic [1:0] len);
        logic [CNT_W-1:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            LEN_WORD: n = 3'd4;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

    // Little-endian insert of one byte into lane idx of a word.
    function automatic logic [DATA_W-1:0] insert_byte(input logic [DATA_W-1:0] word,
                                                      input logic [BYTE_W-1:0] data,
                                                      input logic [1:0]        idx);
        logic [DATA_W-1:0] res;
        res = word;
        res[{idx, 3'b000} +: BYTE_W] = data;
        return res;
    endfunction

    // Little-endian extract of byte lane idx from a word.
    function automatic logic [BYTE_W-1:0] extract_byte(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch word-read port and a load/store port onto
// one byte-wide synchronous RAM. Each transaction is serialised byte by byte,
// little-endian, with the address wrapping modulo 2^32.
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (always 4 bytes)
//   if_data/if_done           fetched word (held) and one-cycle completion
//   mem_req/mem_we/mem_len    load/store request, direction, size
//   mem_addr/mem_wdata        load/store address and store data
//   mem_rdata/mem_done        loaded data (held) and one-cycle completion
//   ram_addr/ram_wr/ram_dout  RAM byte address, write strobe, write byte
//   ram_din                   RAM read byte for the previous cycle's address
//   stallReqIF/stallReqMEM    request pending and not yet done
//
// Timing: all RAM-side outputs and done flags are registered from next-state
// values. A read presents N addresses, then spends one capture-only cycle
// (ram_din lags by one cycle), so done follows the grant edge by N+1 edges;
// a write completes after N edges.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [BYTE_W-1:0] ram_dout,
    input  logic [BYTE_W-1:0] ram_din,
    output logic              stallReqIF,
    output logic              stallReqMEM
);

    state_e            state_q,     state_d;
    port_e             port_q,      port_d;
    port_e             last_q,      last_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [CNT_W-1:0]  n_q,         n_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] work_q,      work_d;
    logic [DATA_W-1:0] if_data_q,   if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              mem_done_q,  mem_done_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_wr_q,    ram_wr_d;
    logic [BYTE_W-1:0] ram_dout_q,  ram_dout_d;
    logic [1:0]        cap_idx_s;
    logic              grant_mem_s;

    // Byte lane receiving ram_din: the byte presented one cycle earlier.
    assign cap_idx_s = cnt_q[1:0] - 2'd1;

    // MEM wins when it is alone, or on a tie when IF was granted last.
    assign grant_mem_s = mem_req && (!if_req || (last_q == PORT_IF));

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        last_d      = last_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        work_d      = work_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_addr_d  = {ADDR_W{1'b0}};
        ram_wr_d    = 1'b0;
        ram_dout_d  = {BYTE_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (grant_mem_s) begin
                    port_d  = PORT_MEM;
                    last_d  = PORT_MEM;
                    base_d  = mem_addr;
                    n_d     = len_to_bytes(mem_len);
                    wdata_d = mem_wdata;
                    work_d  = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = mem_we ? ST_WRITE : ST_READ;
                end else if (if_req) begin
                    port_d  = PORT_IF;
                    last_d  = PORT_IF;
                    base_d  = if_addr;
                    n_d     = 3'd4;
                    wdata_d = {DATA_W{1'b0}};
                    work_d  = {DATA_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // Cycles 1..N each carry the byte addressed in the cycle before.
                if (cnt_q != {CNT_W{1'b0}}) begin
                    work_d = insert_byte(work_q, ram_din, cap_idx_s);
                end else begin
                    work_d = work_q;
                end
                if (cnt_q == n_q) begin
                    state_d = ST_DONE;
                    if (port_q == PORT_IF) begin
                        if_data_d = work_d;
                        if_done_d = 1'b1;
                    end else begin
                        mem_rdata_d = work_d;
                        mem_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == (n_q - 3'd1)) begin
                    state_d = ST_DONE;
                    if (port_q == PORT_IF) begin
                        if_done_d = 1'b1;
                    end else begin
                        mem_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                // Never grant here, so a requester dropping req on done is safe.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // RAM bus for the coming cycle; quiet outside address-issuing cycles.
        if (((state_d == ST_READ) && (cnt_d < n_d)) || (state_d == ST_WRITE)) begin
            ram_addr_d = base_d + {{(ADDR_W-CNT_W){1'b0}}, cnt_d};
        end else begin
            ram_addr_d = {ADDR_W{1'b0}};
        end
        if (state_d == ST_WRITE) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = extract_byte(wdata_d, cnt_d[1:0]);
        end else begin
            ram_wr_d   = 1'b0;
            ram_dout_d = {BYTE_W{1'b0}};
        end
    end

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            port_q      <= PORT_IF;
            last_q      <= PORT_IF;
            base_q      <= {ADDR_W{1'b0}};
            n_q         <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            work_q      <= {DATA_W{1'b0}};
            if_data_q   <= {DATA_W{1'b0}};
            mem_rdata_q <= {DATA_W{1'b0}};
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= {BYTE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            last_q      <= last_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            work_q      <= work_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign if_data   = if_data_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;

    // Gated by rst_in so every output reads zero while reset is held.
    assign stallReqIF  = STALL_IF_EN  & rst_in & if_req  & ~if_done_q;
    assign stallReqMEM = STALL_MEM_EN & rst_in & mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        stallReqIF;
    logic        stallReqMEM;

    int n_vec  = 0;
    int n_miss = 0;

    // Byte RAM model, 4 KiB aliased on the low address bits.
    logic [7:0] ram_m [0:4095];

    mem_arbiter dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_data     (if_data),
        .if_done     (if_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_len     (mem_len),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .ram_addr    (ram_addr),
        .ram_wr      (ram_wr),
        .ram_dout    (ram_dout),
        .ram_din     (ram_din),
        .stallReqIF  (stallReqIF),
        .stallReqMEM (stallReqMEM)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Synchronous RAM: ram_din returns the byte at last cycle's ram_addr.
    always @(posedge clk_in) begin
        if (ram_wr) ram_m[ram_addr[11:0]] <= ram_dout;
        ram_din <= ram_m[ram_addr[11:0]];
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_len   = 2'd0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle_inputs();
        if_req  = 1'b1;
        mem_req = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({if_data, if_done, mem_rdata, mem_done} !== 66'h0) begin
            n_miss++; $display("FAIL reset_port_outs: got %h want 0", {if_data, if_done, mem_rdata, mem_done});
        end
        n_vec++;
        if ({ram_addr, ram_wr, ram_dout} !== 41'h0) begin
            n_miss++; $display("FAIL reset_ram_outs: got %h want 0", {ram_addr, ram_wr, ram_dout});
        end
        n_vec++;
        if ({stallReqIF, stallReqMEM} !== 2'b00) begin
            n_miss++; $display("FAIL reset_stall: got %b want 00", {stallReqIF, stallReqMEM});
        end
        idle_inputs();
        rst_in = 1'b1;
        tick();
        n_vec++;
        if ({ram_addr, ram_wr, if_done, mem_done, stallReqIF, stallReqMEM} !== 37'h0) begin
            n_miss++; $display("FAIL post_reset_idle: got %h want 0", {ram_addr, ram_wr, if_done, mem_done});
        end
    endtask

    task automatic test_store_word();
        logic [31:0] st_addr [0:1];
        logic [31:0] st_data [0:1];
        st_addr = '{32'h0000_0200, 32'h0000_0100};
        st_data = '{32'hDEAD_BEEF, 32'h4433_2211};
        for (int v = 0; v < 2; v++) begin
            int wr_cnt;
            wr_cnt    = 0;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_len   = 2'd2;
            mem_addr  = st_addr[v];
            mem_wdata = st_data[v];
            for (int k = 0; k < 5; k++) begin
                logic [31:0] exp_a;
                logic [7:0]  exp_b;
                tick();
                if (ram_wr) wr_cnt++;
                exp_a = (k < 4) ? st_addr[v] + k : 32'h0;
                exp_b = (k < 4) ? st_data[v][8*k +: 8] : 8'h00;
                n_vec++;
                if ({ram_addr, ram_wr, ram_dout} !== {exp_a, (k < 4), exp_b}) begin
                    n_miss++; $display("FAIL store%0d_bus[%0d]: got %h/%b/%h want %h/%b/%h",
                        v, k, ram_addr, ram_wr, ram_dout, exp_a, (k < 4), exp_b);
                end
                n_vec++;
                if ({mem_done, stallReqMEM} !== {(k == 4), (k != 4)}) begin
                    n_miss++; $display("FAIL store%0d_done[%0d]: got done=%b stall=%b want %b/%b",
                        v, k, mem_done, stallReqMEM, (k == 4), (k != 4));
                end
            end
            n_vec++;
            if (wr_cnt != 4) begin
                n_miss++; $display("FAIL store%0d_wr_cycles: got %0d want 4", v, wr_cnt);
            end
            idle_inputs();
            tick();
            n_vec++;
            if (mem_done !== 1'b0) begin
                n_miss++; $display("FAIL store%0d_done_once: got %b want 0", v, mem_done);
            end
            for (int j = 0; j < 4; j++) begin
                logic [31:0] a;
                a = st_addr[v] + j;
                n_vec++;
                if (ram_m[a[11:0]] !== st_data[v][8*j +: 8]) begin
                    n_miss++; $display("FAIL store%0d_ram[%0d]: got %h want %h", v, j, ram_m[a[11:0]], st_data[v][8*j +: 8]);
                end
            end
        end
    endtask

    task automatic test_if_fetch();
        int stall_cnt;
        stall_cnt = 0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_a;
            tick();
            if (stallReqIF) stall_cnt++;
            exp_a = (k < 4) ? 32'h0000_0100 + k : 32'h0;
            n_vec++;
            if ({ram_addr, ram_wr, if_done, mem_done} !== {exp_a, 1'b0, (k == 5), 1'b0}) begin
                n_miss++; $display("FAIL if_fetch[%0d]: got addr=%h wr=%b done=%b mdone=%b want %h/0/%b/0",
                    k, ram_addr, ram_wr, if_done, mem_done, exp_a, (k == 5));
            end
        end
        n_vec++;
        if (if_data !== 32'h4433_2211) begin
            n_miss++; $display("FAIL if_fetch_data: got %h want 44332211", if_data);
        end
        n_vec++;
        if (stall_cnt != 5) begin
            n_miss++; $display("FAIL if_fetch_stall_cycles: got %0d want 5", stall_cnt);
        end
        idle_inputs();
        tick();
        n_vec++;
        if ({if_done, if_data} !== {1'b0, 32'h4433_2211}) begin
            n_miss++; $display("FAIL if_fetch_hold: got done=%b data=%h want 0/44332211", if_done, if_data);
        end
    endtask

    task automatic test_loads();
        logic [31:0] ld_addr [0:3];
        logic [1:0]  ld_len  [0:3];
        int          ld_n    [0:3];
        logic [31:0] ld_exp  [0:3];
        ld_addr = '{32'h0000_0203, 32'h0000_0201, 32'h0000_0100, 32'h0000_0200};
        ld_len  = '{2'd0, 2'd1, 2'd3, 2'd2};
        ld_n    = '{1, 2, 4, 4};
        ld_exp  = '{32'h0000_00DE, 32'h0000_ADBE, 32'h4433_2211, 32'hDEAD_BEEF};
        for (int v = 0; v < 4; v++) begin
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_len  = ld_len[v];
            mem_addr = ld_addr[v];
            for (int k = 0; k <= ld_n[v] + 1; k++) begin
                logic [31:0] exp_a;
                tick();
                exp_a = (k < ld_n[v]) ? ld_addr[v] + k : 32'h0;
                n_vec++;
                if ({ram_addr, ram_wr, mem_done} !== {exp_a, 1'b0, (k == ld_n[v] + 1)}) begin
                    n_miss++; $display("FAIL load%0d[%0d]: got addr=%h wr=%b done=%b want %h/0/%b",
                        v, k, ram_addr, ram_wr, mem_done, exp_a, (k == ld_n[v] + 1));
                end
            end
            n_vec++;
            if (mem_rdata !== ld_exp[v]) begin
                n_miss++; $display("FAIL load%0d_data: got %h want %h", v, mem_rdata, ld_exp[v]);
            end
            n_vec++;
            if (if_data !== 32'h4433_2211) begin
                n_miss++; $display("FAIL load%0d_if_hold: got %h want 44332211", v, if_data);
            end
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [0:3];
        seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'd2;
        mem_addr  = 32'hFFFF_FFFE;
        mem_wdata = 32'hA4A3_A2A1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (k < 4 && ram_addr !== seq[k]) begin
                n_miss++; $display("FAIL wrap_store_addr[%0d]: got %h want %h", k, ram_addr, seq[k]);
            end else if (k == 4 && mem_done !== 1'b1) begin
                n_miss++; $display("FAIL wrap_store_done: got %b want 1", mem_done);
            end
        end
        idle_inputs();
        tick();
        mem_req  = 1'b1;
        mem_len  = 2'd2;
        mem_addr = 32'hFFFF_FFFE;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_a;
            tick();
            exp_a = (k < 4) ? seq[k] : 32'h0;
            n_vec++;
            if ({ram_addr, mem_done} !== {exp_a, (k == 5)}) begin
                n_miss++; $display("FAIL wrap_load[%0d]: got %h/%b want %h/%b", k, ram_addr, mem_done, exp_a, (k == 5));
            end
        end
        n_vec++;
        if (mem_rdata !== 32'hA4A3_A2A1) begin
            n_miss++; $display("FAIL wrap_load_data: got %h want a4a3a2a1", mem_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_arbitration();
        logic [31:0] arb_addr [0:13];
        arb_addr = '{32'h200, 32'h0, 32'h0, 32'h0, 32'h100, 32'h101, 32'h102,
                     32'h103, 32'h0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0};
        rst_in = 1'b0;
        idle_inputs();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0100;
        mem_req  = 1'b1;
        mem_len  = 2'd0;
        mem_addr = 32'h0000_0200;
        tick();
        rst_in = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            n_vec++;
            if ({ram_addr, if_done, mem_done} !== {arb_addr[k], (k == 9), (k == 2 || k == 13)}) begin
                n_miss++; $display("FAIL arb[%0d]: got addr=%h ifd=%b md=%b want %h/%b/%b",
                    k, ram_addr, if_done, mem_done, arb_addr[k], (k == 9), (k == 2 || k == 13));
            end
            if (k == 2 || k == 13) begin
                n_vec++;
                if (mem_rdata !== 32'h0000_00EF) begin
                    n_miss++; $display("FAIL arb_mem_data[%0d]: got %h want 000000ef", k, mem_rdata);
                end
            end
            if (k == 9) begin
                n_vec++;
                if (if_data !== 32'h4433_2211) begin
                    n_miss++; $display("FAIL arb_if_data: got %h want 44332211", if_data);
                end
            end
            // Both requests drop mid-transaction; the MEM load must still finish.
            if (k == 11) idle_inputs();
        end
        tick();
    endtask

    task automatic test_reset_mid();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (ram_addr !== 32'h0000_0100 + k) begin
                n_miss++; $display("FAIL rmid_addr[%0d]: got %h want %h", k, ram_addr, 32'h0000_0100 + k);
            end
        end
        rst_in = 1'b0;
        #1;
        n_vec++;
        if ({if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stallReqIF, stallReqMEM} !== 109'h0) begin
            n_miss++; $display("FAIL rmid_outputs: got ifd=%h addr=%h stall=%b want all 0", if_data, ram_addr, stallReqIF);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({if_done, ram_addr} !== 33'h0) begin
                n_miss++; $display("FAIL rmid_held[%0d]: got done=%b addr=%h want 0/0", k, if_done, ram_addr);
            end
        end
        rst_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp_a;
            tick();
            exp_a = (k < 4) ? 32'h0000_0100 + k : 32'h0;
            n_vec++;
            if ({ram_addr, if_done} !== {exp_a, (k == 5)}) begin
                n_miss++; $display("FAIL rmid_refetch[%0d]: got %h/%b want %h/%b", k, ram_addr, if_done, exp_a, (k == 5));
            end
        end
        n_vec++;
        if (if_data !== 32'h4433_2211) begin
            n_miss++; $display("FAIL rmid_refetch_data: got %h want 44332211", if_data);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_if_fetch();
        test_loads();
        test_wrap();
        test_arbitration();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk_in, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports if_req (in, 1), if_addr (in, 32), if_data (out, 32), if_done (out, 1): instruction-fetch word read port.
REQ-004 SHALL have ports mem_req (in, 1), mem_we (in, 1), mem_len (in, 2), mem_addr (in, 32), mem_wdata (in, 32), mem_rdata (out, 32), mem_done (out, 1): load/store port.
REQ-005 SHALL have ports ram_addr (out, 32), ram_wr (out, 1), ram_dout (out, 8), ram_din (in, 8): shared byte-wide RAM; ram_din returns the byte at the ram_addr presented in the previous cycle.
REQ-006 SHALL have ports stallReqIF (out, 1) and stallReqMEM (out, 1): stall requests to the stall controller feeding the stage-register stall vector.
REQ-007 SHALL decode mem_len as 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and SHALL be treated as 4 bytes.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-009 In IDLE, SHALL sample if_req/mem_req each edge; grant goes to one requester; the other keeps waiting.
REQ-010 Arbitration: with both requests pending, grant SHALL go to the requester not granted last; after reset, MEM wins the first tie.
REQ-011 On grant, SHALL latch base address, byte count N (IF: 4), direction and write data; IDLE -> READ or WRITE.
REQ-012 READ: SHALL present base+i on ram_addr for i = 0..N-1 in consecutive cycles; byte i SHALL be captured from ram_din one cycle later into bits [8i+7:8i]; unused upper bytes zero.
REQ-013 WRITE: SHALL drive ram_wr=1, ram_addr=base+i, ram_dout=wdata[8i+7:8i] for i = 0..N-1 in consecutive cycles; little-endian.
REQ-014 Address increment SHALL wrap modulo 2^32; misaligned addresses are legal and need no special handling.
REQ-015 After the last byte (read: captured; write: issued), FSM SHALL enter DONE for exactly one cycle, asserting the granted port's done for that cycle only, then return to IDLE.
REQ-016 Latency from grant edge to done-high cycle SHALL be N+1 cycles for reads and N cycles for writes (IF word fetch: 5).
REQ-017 if_data/mem_rdata SHALL hold the last completed read value until the next read completes on that port.
REQ-018 ram_wr SHALL be 0 in every non-WRITE cycle; ram_addr and ram_dout SHALL be 0 in IDLE and DONE.
REQ-019 stallReqIF SHALL equal if_req AND NOT if_done, combinationally; stallReqMEM likewise with mem_req/mem_done.
REQ-020 Requesters hold req and operands stable until done; req deasserted mid-transaction SHALL NOT abort it; done still pulses.
REQ-021 No request SHALL be granted in the DONE cycle, so a requester dropping req on done is never re-granted.

Reset
REQ-022 rst_in low SHALL immediately force IDLE, all outputs 0, last-grant flag to IF; an in-flight transaction is abandoned with no done pulse.
REQ-023 After rst_in rises, first grant SHALL be possible at the first edge.

Structure
REQ-024 Widths, mem_len encodings, FSM state encodings and stall-request enables SHALL live in the shared defines.vh.
REQ-025 A single module; no sub-module is required; byte assembly is a shift/insert within it.

Verification
REQ-026 IF only, if_addr=0x100, RAM[0x100..0x103]=11,22,33,44 -> if_done in 5th cycle after grant, if_data=0x44332211, stallReqIF high 5 cycles.
REQ-027 MEM store word 0xDEADBEEF at 0x200 -> ram_wr high 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203, mem_done 4 cycles after grant.
REQ-028 MEM load byte at 0x203 after REQ-027 -> mem_rdata=0x000000DE, mem_done 2 cycles after grant.
REQ-029 if_req and mem_req both high from reset -> MEM granted first, IF granted in the IDLE cycle after DONE, then with both pending again MEM next.
REQ-030 Load word at 0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-031 rst_in low during 3rd byte of IF fetch -> all outputs 0 at once, no if_done; new fetch after release completes normally.
